tv_capture: RTL

- Receive side of the 1-bit composite TV link: decodes active-low composite sync (sync_) plus 1-bit video (vin) and captures the 512x240 active area into a byte-wide video RAM write port.
- Layout matches the transmit side's vMem: 8 pixels per byte, MSB = leftmost pixel, 64 bytes per line.
- Sits between the external video/sync pins and a dual-port frame buffer; downstream logic sees lineStb/frameStb/locked/yPos.

---
 rtl/tv_capture_pkg.sv | 11 +
 rtl/tv_capture_if.sv | 12 +
 rtl/tv_sync_sep.sv | 39 +++
 rtl/tv_capture.sv | 90 +++++++++
 4 files changed

// File: rtl/tv_capture_pkg.sv
// tv_capture_pkg: TV timing constants shared by transmit and receive sides, plus capture state encoding
package tv_capture_pkg;
   localparam int CLK_PER_PIX = 5;
   localparam int LINE_PIX    = 640;
   localparam int LINES       = 259;
   localparam int ACT_X       = 512;
   localparam int ACT_Y       = 240;
   localparam int HS_X        = 534;
   localparam int VS_LINE     = 244;
   typedef enum logic [1:0] {IDLE, WAIT, SHIFT} cap_state_t;
endpackage

// File: rtl/tv_capture_if.sv
// tv_capture_if: video RAM write port and timing status presented to the frame buffer side
interface tv_capture_if;
   logic        wrEn;
   logic [13:0] wrAddr;
   logic [7:0]  wrData;
   logic        lineStb;
   logic        frameStb;
   logic        locked;
   logic [8:0]  yPos;
   modport master(output wrEn, wrAddr, wrData, lineStb, frameStb, locked, yPos);
   modport slave(input wrEn, wrAddr, wrData, lineStb, frameStb, locked, yPos);
endinterface

// File: rtl/tv_sync_sep.sv
// tv_sync_sep: synchronises sync_/vin and classifies each sync low pulse by its width
module tv_sync_sep #(
   parameter int HMIN = 150,
   parameter int HMAX = 400,
   parameter int VMIN = 1000
)(
   input  logic        clk,
   input  logic        rst_,
   input  logic        sync_,
   input  logic        vin,
   output logic        vid,
   output logic        fallStb,
   output logic        hsStb,
   output logic        vsStb,
   output logic        badStb,
   output logic [12:0] lowCnt
);
   logic [2:0] s;
   logic [1:0] v;
   logic       rise;
   assign vid     = v[1];
   assign fallStb = s[2] & ~s[1];
   assign rise    = ~s[2] & s[1];
   assign hsStb   = rise && lowCnt >= 13'(HMIN) && lowCnt <= 13'(HMAX);
   assign badStb  = rise && lowCnt > 13'(HMAX) && lowCnt < 13'(VMIN);
   assign vsStb   = rise && lowCnt >= 13'(VMIN);
   // s[2] only feeds edge detection, so sync_ and vin both see two flops of latency
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         s      <= '0;
         v      <= '0;
         lowCnt <= '0;
      end else begin
         s      <= {s[1:0], sync_};
         v      <= {v[0], vin};
         lowCnt <= fallStb ? '0 : (!s[1] && lowCnt != '1) ? lowCnt + 13'd1 : lowCnt;
      end
   end
endmodule

// File: rtl/tv_capture.sv
// tv_capture: decodes composite sync and captures the active picture into a byte-wide video RAM port
module tv_capture
   import tv_capture_pkg::*;
#(
   parameter int CPP    = CLK_PER_PIX,
   parameter int LPIX   = LINE_PIX,
   parameter int NLINES = LINES,
   parameter int AX     = ACT_X,
   parameter int AY     = ACT_Y,
   parameter int HSX    = HS_X,
   parameter int VSL    = VS_LINE,
   parameter int HMIN   = 150,
   parameter int HMAX   = 400,
   parameter int VMIN   = 1000
)(
   input logic          clk,
   input logic          rst_,
   input logic          sync_,
   input logic          vin,
   tv_capture_if.master vo
);
   localparam int HOFS = (LPIX - HSX) * CPP;
   localparam int TMO  = 2 * LPIX * CPP;
   logic        vid, fallStb, hsStb, vsStb, badStb;
   logic [12:0] lowCnt, lineClk, tmo;
   logic [8:0]  linesSeen, ny, pix;
   logic [2:0]  ph;
   logic [6:0]  sh;
   logic        vs_seen, tmo_stb, smp, cap_ok, wr;
   cap_state_t  state, state_d;

   tv_sync_sep #(.HMIN(HMIN), .HMAX(HMAX), .VMIN(VMIN)) u_sep (
      .clk(clk), .rst_(rst_), .sync_(sync_), .vin(vin), .vid(vid), .fallStb(fallStb),
      .hsStb(hsStb), .vsStb(vsStb), .badStb(badStb), .lowCnt(lowCnt)
   );

   assign ny      = (vo.yPos == 9'(NLINES - 1)) ? 9'd0 : vo.yPos + 9'd1;
   assign cap_ok  = vo.locked && ny < 9'(AY);
   assign tmo_stb = tmo == 13'(TMO - 1) && !hsStb && !vsStb;
   assign smp     = state == SHIFT && ph == 3'(CPP / 2);
   assign wr      = smp && pix[2:0] == 3'd7 && state_d == SHIFT;

   always_comb begin
      state_d = hsStb ? (cap_ok ? WAIT : IDLE)
              : (badStb || tmo_stb || (fallStb && state == SHIFT)) ? IDLE
              : (state == WAIT && lineClk == 13'(HOFS - 1)) ? SHIFT
              : (state == SHIFT && ph == 3'(CPP - 1) && pix == 9'(AX - 1)) ? IDLE
              : state;
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state <= IDLE;
      else state <= state_d;
   end

   // lineClk is the offset of the current cycle from the last qualified hsync fall; glitches leave it alone
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         lineClk     <= '0;
         tmo         <= '0;
         linesSeen   <= '0;
         vs_seen     <= 1'b0;
         ph          <= '0;
         pix         <= '0;
         sh          <= '0;
         vo.wrEn     <= 1'b0;
         vo.wrAddr   <= '0;
         vo.wrData   <= '0;
         vo.lineStb  <= 1'b0;
         vo.frameStb <= 1'b0;
         vo.locked   <= 1'b0;
         vo.yPos     <= '0;
      end else begin
         lineClk     <= hsStb ? lowCnt + 13'd2 : (lineClk == '1) ? lineClk : lineClk + 13'd1;
         tmo         <= (hsStb || vsStb) ? '0 : (tmo == 13'(TMO)) ? tmo : tmo + 13'd1;
         linesSeen   <= vsStb ? '0 : (hsStb && linesSeen != '1) ? linesSeen + 9'd1 : linesSeen;
         vs_seen     <= vs_seen | vsStb;
         ph          <= (state == SHIFT && ph != 3'(CPP - 1)) ? ph + 3'd1 : '0;
         pix         <= (state != SHIFT) ? '0 : (ph == 3'(CPP - 1)) ? pix + 9'd1 : pix;
         sh          <= smp ? {sh[5:0], vid} : sh;
         vo.wrEn     <= wr;
         vo.wrAddr   <= wr ? {vo.yPos[7:0], pix[8:3]} : vo.wrAddr;
         vo.wrData   <= wr ? {sh, vid} : vo.wrData;
         vo.lineStb  <= hsStb;
         vo.frameStb <= vsStb;
         vo.locked   <= vsStb ? (vs_seen && linesSeen == 9'(NLINES)) : (badStb || tmo_stb) ? 1'b0 : vo.locked;
         vo.yPos     <= vsStb ? 9'(VSL) : hsStb ? ny : vo.yPos;
      end
   end
endmodule
